// File: rtl/if_fetch_pkg.sv
// Shared configuration for the instruction-fetch stage: widths, reset PC,
// bubble word and stall-vector bit indices.
package if_fetch_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned STALL_W    = 6;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam int unsigned STALL_PC = 0;
  localparam int unsigned STALL_IF = 1;

endpackage

// File: rtl/if_inst_buf.sv
// One-entry holding register for a fetched instruction.
// Flush beats fill beats consume.
module if_inst_buf import if_fetch_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_WIDTH,
  parameter int unsigned INST_W = INST_WIDTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_pc,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              consume,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      pc    <= fill_pc;
      inst  <= fill_inst;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding memory reads,
// buffers one instruction for IF/ID and handles branch redirects.
module if_fetch import if_fetch_pkg::*; #(
  parameter int unsigned          ADDR_W   = ADDR_WIDTH,
  parameter int unsigned          INST_W   = INST_WIDTH,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(if_fetch_pkg::RESET_PC)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INST_W-1:0]  mem_rdata,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INST_W-1:0]  if_inst,
  output logic               stallreq_if
);

  typedef enum logic {S_IDLE, S_WAIT} fetch_state_t;

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              kill, kill_n;
  logic              req_n;
  logic [ADDR_W-1:0] addr_n;
  logic              buf_fill;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [INST_W-1:0] buf_inst;
  logic              consume;
  logic              unused_inputs;

  assign unused_inputs = ^{stall[STALL_W-1:2], branch_target[1:0]};

  assign consume = buf_valid && !stall[STALL_IF];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      kill     <= kill_n;
      mem_req  <= req_n;
      mem_addr <= addr_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    kill_n   = kill;
    req_n    = mem_req;
    addr_n   = mem_addr;
    buf_fill = 1'b0;
    if (branch_flag) begin
      // The request cannot be aborted: either it completes now (drop data)
      // or it is marked for discard when its ack eventually arrives.
      pc_n = {branch_target[ADDR_W-1:2], 2'b00};
      if (state == S_WAIT) begin
        if (mem_ack) begin
          state_n = S_IDLE;
          req_n   = 1'b0;
          kill_n  = 1'b0;
        end else begin
          kill_n = 1'b1;
        end
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!stall[STALL_PC] && (!buf_valid || consume)) begin
            req_n   = 1'b1;
            addr_n  = pc;
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            req_n   = 1'b0;
            state_n = S_IDLE;
            if (kill) begin
              kill_n = 1'b0;
            end else begin
              buf_fill = 1'b1;
              pc_n     = mem_addr + ADDR_W'(4);
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  if_inst_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (branch_flag),
    .fill      (buf_fill),
    .fill_pc   (mem_addr),
    .fill_inst (mem_rdata),
    .consume   (consume),
    .valid     (buf_valid),
    .pc        (buf_pc),
    .inst      (buf_inst)
  );

  assign if_pc       = buf_valid ? buf_pc : '0;
  assign if_inst     = buf_valid ? buf_inst : INST_W'(ZeroWord);
  assign stallreq_if = !buf_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed phases push expected requests and
// IF/ID deliveries; a monitor compares them as the DUT presents them.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  fetch_t      exp_q[$];
  logic [31:0] addr_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          ack_wait = 0;
  int          wait_cnt = 0;
  int          stray_req = 0;
  int          stray_done = 0;
  logic        prev_req = 1'b0;
  logic [31:0] cur_addr = 32'h0;

  always #5 CLK = ~CLK;

  if_fetch #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .stallreq_if   (stallreq_if)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h000: mem_word = 32'h0050_0013;
      32'h004: mem_word = 32'h00A0_0093;
      32'h008: mem_word = 32'h00B0_0113;
      32'h00C: mem_word = 32'h00C0_0193;
      32'h100: mem_word = 32'h1110_0013;
      32'h200: mem_word = 32'h2220_0013;
      default: mem_word = 32'hDEAD_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    int n = 0;
    while (!(mem_req === 1'b1 && mem_addr === a) && n < 60) begin
      tick();
      n++;
    end
    check(name, {63'b0, (mem_req === 1'b1 && mem_addr === a)}, 64'd1);
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (mem_ack !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check(name, {63'b0, mem_ack}, 64'd1);
  endtask

  // Memory responder: acks after ack_wait idle cycles, plus injectable stray acks.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (stray_req != stray_done) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        stray_done++;
      end else if (mem_req) begin
        if (wait_cnt >= ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: IF/ID deliveries, bubble zeros, request addresses and stability.
  initial begin
    fetch_t      e;
    logic [31:0] ea;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (!stallreq_if && !stall[STALL_IF]) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL consume: got pc %h inst %h, expected no delivery", if_pc, if_inst);
          end else begin
            e = exp_q.pop_front();
            check("consume_pc", {32'h0, if_pc}, {32'h0, e.pc});
            check("consume_inst", {32'h0, if_inst}, {32'h0, e.inst});
          end
        end
        if (stallreq_if) begin
          check("bubble_word", {if_pc, if_inst}, 64'h0);
        end
        if (mem_req && !prev_req) begin
          if (addr_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL req_addr: got request to %h, expected no request", mem_addr);
          end else begin
            ea = addr_q.pop_front();
            cur_addr = ea;
            check("req_addr", {32'h0, mem_addr}, {32'h0, ea});
          end
        end else if (mem_req && prev_req) begin
          check("addr_stable", {32'h0, mem_addr}, {32'h0, cur_addr});
        end
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    stall = 6'b0;
    branch_flag = 1'b0;
    branch_target = 32'h0;
    #1;
    check("rst_outputs", {if_pc, if_inst}, 64'h0);
    check("rst_req", {62'b0, mem_req, stallreq_if}, 64'd1);
    check("rst_addr", {32'h0, mem_addr}, 64'h0);
    tick();
    RST = 1'b0;

    // Streaming fetch with one-cycle memory.
    addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    addr_q.push_back(32'h8); addr_q.push_back(32'hC);
    exp_q.push_back('{32'h0, 32'h0050_0013});
    exp_q.push_back('{32'h4, 32'h00A0_0093});
    exp_q.push_back('{32'h8, 32'h00B0_0113});
    exp_q.push_back('{32'hC, 32'h00C0_0193});
    wait_req(32'hC, "stream_reach_c");
    stall[STALL_PC] = 1'b1;
    repeat (4) tick();

    // stall[0] with empty buffer: nothing issues until released.
    for (int unsigned i = 0; i < 3; i++) begin
      check("pcstall_idle", {62'b0, mem_req, stallreq_if}, 64'd1);
      tick();
    end
    addr_q.push_back(32'h10);
    exp_q.push_back('{32'h10, 32'hDEAD_0010});
    stall[STALL_PC] = 1'b0;
    tick();
    check("pcstall_release", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, 32'h10});
    stall[STALL_PC] = 1'b1;
    repeat (4) tick();

    // IF/ID stall holds the buffered instruction at pc 4.
    branch_flag = 1'b1; branch_target = 32'h4;
    tick();
    branch_flag = 1'b0;
    stall[STALL_IF] = 1'b1;
    addr_q.push_back(32'h4);
    stall[STALL_PC] = 1'b0;
    wait_req(32'h4, "hold_req4");
    begin
      int n = 0;
      while (stallreq_if !== 1'b0 && n < 20) begin tick(); n++; end
    end
    for (int unsigned i = 0; i < 3; i++) begin
      check("hold_word", {if_pc, if_inst}, {32'h4, 32'h00A0_0093});
      check("hold_noreq", {63'b0, mem_req}, 64'd0);
      tick();
    end

    // Release: delivery of pc 4, back-to-back request to 8, branch kills it.
    exp_q.push_back('{32'h4, 32'h00A0_0093});
    addr_q.push_back(32'h8);
    addr_q.push_back(32'h100);
    exp_q.push_back('{32'h100, 32'h1110_0013});
    ack_wait = 3;
    stall[STALL_IF] = 1'b0;
    tick();
    check("release_req8", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, 32'h8});
    branch_flag = 1'b1; branch_target = 32'h100;
    tick();
    branch_flag = 1'b0;
    wait_ack("killed_ack");
    ack_wait = 0;
    wait_req(32'h100, "redirect_req100");
    stall[STALL_PC] = 1'b1;
    repeat (4) tick();

    // Branch coincident with ack at 0xC, misaligned target 0x203.
    branch_flag = 1'b1; branch_target = 32'hC;
    tick();
    branch_flag = 1'b0;
    addr_q.push_back(32'hC);
    addr_q.push_back(32'h200);
    exp_q.push_back('{32'h200, 32'h2220_0013});
    stall[STALL_PC] = 1'b0;
    begin
      int n = 0;
      while (!(mem_ack === 1'b1 && mem_addr === 32'hC) && n < 20) begin tick(); n++; end
    end
    check("coincident_ack_c", {31'b0, mem_ack, mem_addr}, {31'b0, 1'b1, 32'hC});
    branch_flag = 1'b1; branch_target = 32'h203;
    tick();
    branch_flag = 1'b0;
    wait_req(32'h200, "aligned_req200");
    stall[STALL_PC] = 1'b1;
    repeat (4) tick();

    // Reset in the middle of a slow fetch.
    ack_wait = 5;
    addr_q.push_back(32'h204);
    stall[STALL_PC] = 1'b0;
    wait_req(32'h204, "pre_reset_req");
    tick();
    RST = 1'b1;
    #1;
    check("async_rst_req", {63'b0, mem_req}, 64'd0);
    check("async_rst_word", {if_pc, if_inst}, 64'h0);
    check("async_rst_stallreq", {63'b0, stallreq_if}, 64'd1);
    stall[STALL_PC] = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    stray_req++;
    repeat (3) tick();
    check("stray_ack_ignored", {62'b0, mem_req, stallreq_if}, 64'd1);
    ack_wait = 0;
    addr_q.push_back(32'h0);
    exp_q.push_back('{32'h0, 32'h0050_0013});
    stall[STALL_PC] = 1'b0;
    tick();
    check("post_reset_req", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, 32'h0});
    stall[STALL_PC] = 1'b1;
    repeat (5) tick();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("addr_q_drained", 64'(addr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one-outstanding-request reads to instruction memory.
- Buffers one fetched instruction and presents it as if_pc/if_inst.
- Handles branch redirects: flushes the buffer and kills any in-flight fetch. Zero words on if_pc/if_inst denote a bubble.

Parameters:
- ADDR_W, 32, PC/address width
- INST_W, 32, instruction width
- RESET_PC, 0, PC value after reset

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- stall  in  6  pipeline stall vector from control; bit0 = PC/IF, bit1 = IF/ID
- branch_flag  in  1  one-cycle redirect request
- branch_target  in  ADDR_W  redirect address
- mem_req  out  1  instruction read request
- mem_addr  out  ADDR_W  request address, stable while mem_req=1
- mem_ack  in  1  one-cycle completion; data valid in the same cycle
- mem_rdata  in  INST_W  fetched instruction
- if_pc  out  ADDR_W  PC of buffered instruction, else 0
- if_inst  out  INST_W  buffered instruction, else 0
- stallreq_if  out  1  no valid instruction available (buffer empty)

Behaviour:
- Reset (async, highest priority):
  - pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=0, kill=0, buf_valid=0.
  - Outputs if_pc=0, if_inst=0, stallreq_if=1.
- Registers: pc, state {IDLE, WAIT}, kill, buf_valid, buf_pc, buf_inst, mem_req, mem_addr.
- Outputs are combinational from the buffer:
  - if_pc = buf_valid ? buf_pc : 0
  - if_inst = buf_valid ? buf_inst : 0
  - stallreq_if = !buf_valid
- Consume:
  - consume = buf_valid && stall[1]==0. IF/ID samples the outputs at that same edge.
  - The buffer clears at that edge unless refilled at the same edge.
- IDLE:
  - Issue when stall[0]==0 and (buf empty or consume) and no branch_flag.
  - On issue at edge: mem_req<=1, mem_addr<=pc, state<=WAIT.
  - Otherwise stay in IDLE with mem_req=0.
- WAIT:
  - mem_req stays 1 and mem_addr is held until mem_ack. There is no abort.
  - On mem_ack with kill=0: buf_valid<=1, buf_pc<=mem_addr, buf_inst<=mem_rdata, pc<=mem_addr+4, mem_req<=0, state<=IDLE.
  - On mem_ack with kill=1: discard the data, kill<=0, mem_req<=0, state<=IDLE. pc is not modified because it already holds the target.
  - Minimum fetch latency is 2 cycles (issue edge, then ack). Back-to-back fetch is possible when ack and consume coincide with the next issue from IDLE on the following cycle.
- Buffer-full rule:
  - A request is only issued when the buffer has room, so an ack never arrives while the buffer is occupied.
- Branch (branch_flag=1), priority below reset and above everything else:
  - pc<=branch_target with bits [1:0] forced to 00.
  - buf_valid<=0 (wrong-path instruction dropped).
  - If state==WAIT and mem_ack==0: kill<=1.
  - If state==WAIT and mem_ack==1: the ack data is discarded, kill stays 0, state<=IDLE.
  - No new request is issued in the branch cycle.
  - A branch while kill=1 updates pc again; kill stays 1.
- stall[0]=1:
  - Blocks new issues only.
  - An in-flight fetch still completes into the buffer; pc advances only through that ack.
- PC arithmetic is modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0.
- Reset mid-WAIT:
  - mem_req drops immediately (asynchronously).
  - A late mem_ack arriving after reset is ignored because state==IDLE.

Decomposition:
- Shared config include holds ADDR_WIDTH, INST_WIDTH, ZeroWord, RESET_PC and the stall-bit indices (STALL_PC=0, STALL_IF=1).
- The fetch FSM state encoding is local to the module.
- One natural sub-module: if_inst_buf, the one-entry valid/pc/inst holding register with fill, consume and flush inputs.

Test Plan:
- Reset, then memory acks 1 cycle after each req, stall=0 -> mem_addr sequence 0,4,8,0xC; if_inst matches memory; stallreq_if=1 only while fetches are outstanding.
- Buffer holds inst 0x00A00093 at pc 4 and stall[1]=1 for 3 cycles -> if_pc=4 and if_inst=0x00A00093 held, mem_req=0; on release, next req to addr 8.
- Branch to 0x100 while a fetch at 0x8 is waiting 3 cycles for ack -> mem_addr held at 8 until ack; ack data dropped; next req to 0x100; IF/ID never receives the pc=8 instruction.
- Branch coincident with mem_ack at pc 0xC, target 0x203 -> data dropped, kill=0, next req to 0x200.
- stall[0]=1 with buffer empty and IDLE -> no req, stallreq_if=1; deassert -> req at current pc the next edge.
- RST asserted mid-WAIT -> mem_req=0, if_pc=0 and if_inst=0 immediately; stray ack ignored; after release, first req to RESET_PC.
